// File: rtl/crank_emulator_if.sv
// Crank emulator bundle: run/config toward the emulator,
// tooth signal and revolution status back.
interface crank_emulator_if #(
  parameter int PW = 24,
  parameter int TW = 8
);
  logic          ena;
  logic [PW-1:0] period;
  logic [TW-1:0] teeth_total;
  logic [3:0]    teeth_missing;
  logic          vr_sig;
  logic [TW-1:0] tooth_num;
  logic          gap;
  logic          rev_pulse;
  logic [15:0]   rev_cnt;
  logic          busy;
  logic          cfg_err;

  modport master (
    output ena, period, teeth_total, teeth_missing,
    input  vr_sig, tooth_num, gap, rev_pulse,
    input  rev_cnt, busy, cfg_err
  );

  modport slave (
    input  ena, period, teeth_total, teeth_missing,
    output vr_sig, tooth_num, gap, rev_pulse,
    output rev_cnt, busy, cfg_err
  );
endinterface

// File: rtl/crank_emulator.sv
// Missing-tooth crank wheel emulator: drives a VR-style tooth
// train with period/tooth shadows reloaded on tooth/rev wraps.
module crank_emulator #(
  parameter int PW = 24,
  parameter int TW = 8
) (
  input  logic clk,
  input  logic rst,
  crank_emulator_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [1:0]    rst_q;
  logic          rst_i;
  logic [PW-1:0] pcnt, period_s, period_fix;
  logic [TW-1:0] tooth, total_s, real_n;
  logic [3:0]    missing_s;
  logic [15:0]   rev_cnt;
  logic          rev_pulse, cfg_err;
  logic          cfg_ok, pwrap, twrap, go;
  logic          busy, vr_sig, gap;

  // Assert immediately, release after two edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= '0;
    else      rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_i = rst_q[1];

  assign cfg_ok = (bus.teeth_total >= TW'(3))
    && (bus.teeth_missing != 4'd0)
    && ({4'b0, bus.teeth_total}
        >= ({{TW{1'b0}}, bus.teeth_missing} + (TW+4)'(2)));

  assign period_fix = (bus.period < PW'(2)) ? PW'(2)
                                            : bus.period;
  assign pwrap  = (pcnt == period_s - PW'(1));
  assign twrap  = pwrap && (tooth == total_s - TW'(1));
  assign go     = bus.ena && cfg_ok;
  assign real_n = total_s - TW'(missing_s);

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = RUN;
      RUN: begin
        if (!bus.ena || (twrap && !cfg_ok))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    vr_sig = busy && (pcnt < (period_s >> 1))
                  && (tooth < real_n);
    gap    = busy && (tooth >= real_n);
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      pcnt      <= '0;
      tooth     <= '0;
      rev_cnt   <= '0;
      period_s  <= '0;
      total_s   <= '0;
      missing_s <= '0;
      rev_pulse <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      rev_pulse <= 1'b0;
      cfg_err   <= 1'b0;
      if (state == IDLE) begin
        pcnt      <= '0;
        tooth     <= '0;
        rev_pulse <= go;
        cfg_err   <= bus.ena && !cfg_ok;
        if (go) begin
          period_s  <= period_fix;
          total_s   <= bus.teeth_total;
          missing_s <= bus.teeth_missing;
        end
      end else if (!bus.ena) begin
        pcnt  <= '0;
        tooth <= '0;
      end else if (pwrap) begin
        pcnt     <= '0;
        period_s <= period_fix;
        if (twrap) begin
          tooth     <= '0;
          rev_cnt   <= rev_cnt + 16'd1;
          total_s   <= bus.teeth_total;
          missing_s <= bus.teeth_missing;
          rev_pulse <= cfg_ok;
          cfg_err   <= !cfg_ok;
        end else begin
          tooth <= tooth + TW'(1);
        end
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  assign bus.vr_sig    = vr_sig;
  assign bus.tooth_num = tooth;
  assign bus.gap       = gap;
  assign bus.rev_pulse = rev_pulse;
  assign bus.rev_cnt   = rev_cnt;
  assign bus.busy      = busy;
  assign bus.cfg_err   = cfg_err;
endmodule

// File: tb/tb_crank_emulator.sv
// Directed bench for crank_emulator: tooth train, shadows,
// config rejection, enable and reset behaviour.
module tb_crank_emulator;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   n, vr_n, gap_n, rp_n;

  always #5 clk = ~clk;

  crank_emulator_if #(.PW(24), .TW(8)) bus ();

  crank_emulator #(.PW(24), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.ena = 1'b0;
    bus.period = 24'd10;
    bus.teeth_total = 8'd6;
    bus.teeth_missing = 4'd2;
    step(3);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_vr", 32'(bus.vr_sig), 0);
    chk("rst_gap", 32'(bus.gap), 0);
    chk("rst_rp", 32'(bus.rev_pulse), 0);
    chk("rst_revcnt", 32'(bus.rev_cnt), 0);
    chk("rst_cfgerr", 32'(bus.cfg_err), 0);
    chk("rst_tooth", 32'(bus.tooth_num), 0);

    // release with enable already high
    rst = 1'b1;
    bus.ena = 1'b1;
    step(1);
    chk("sync_hold", 32'(bus.busy), 0);
    n = 0;
    while (!bus.busy && n < 5) begin
      step(1);
      n++;
    end
    chk("run_entry", 32'(bus.busy), 1);
    chk("k0_rp", 32'(bus.rev_pulse), 1);
    chk("k0_tooth", 32'(bus.tooth_num), 0);
    chk("k0_vr", 32'(bus.vr_sig), 1);
    step(1);
    chk("k1_rp", 32'(bus.rev_pulse), 0);
    step(3);
    chk("k4_vr", 32'(bus.vr_sig), 1);
    step(1);
    chk("k5_vr", 32'(bus.vr_sig), 0);
    step(5);
    chk("k10_tooth", 32'(bus.tooth_num), 1);
    chk("k10_vr", 32'(bus.vr_sig), 1);
    step(30);
    chk("k40_tooth", 32'(bus.tooth_num), 4);
    chk("k40_gap", 32'(bus.gap), 1);
    chk("k40_vr", 32'(bus.vr_sig), 0);
    step(20);
    chk("k60_tooth", 32'(bus.tooth_num), 0);
    chk("k60_rp", 32'(bus.rev_pulse), 1);
    chk("k60_revcnt", 32'(bus.rev_cnt), 1);
    chk("k60_gap", 32'(bus.gap), 0);
    step(60);
    vr_n = 0;
    gap_n = 0;
    rp_n = 0;
    for (int i = 0; i < 60; i++) begin
      vr_n  += int'(bus.vr_sig);
      gap_n += int'(bus.gap);
      rp_n  += int'(bus.rev_pulse);
      step(1);
    end
    chk("rev_vr_clks", 32'(vr_n), 20);
    chk("rev_gap_clks", 32'(gap_n), 20);
    chk("rev_pulses", 32'(rp_n), 1);
    chk("k180_revcnt", 32'(bus.rev_cnt), 3);
    chk("k180_rp", 32'(bus.rev_pulse), 1);

    // period change at pcnt=3 of tooth 0
    step(3);
    bus.period = 24'd20;
    step(6);
    chk("k189_tooth", 32'(bus.tooth_num), 0);
    step(1);
    chk("k190_tooth", 32'(bus.tooth_num), 1);
    chk("k190_vr", 32'(bus.vr_sig), 1);
    step(9);
    chk("k199_vr", 32'(bus.vr_sig), 1);
    step(1);
    chk("k200_vr", 32'(bus.vr_sig), 0);
    chk("k200_tooth", 32'(bus.tooth_num), 1);
    step(9);
    chk("k209_tooth", 32'(bus.tooth_num), 1);
    step(1);
    chk("k210_tooth", 32'(bus.tooth_num), 2);

    // stop at tooth 2, pcnt 7
    step(7);
    chk("k217_tooth", 32'(bus.tooth_num), 2);
    bus.ena = 1'b0;
    step(1);
    chk("stop_vr", 32'(bus.vr_sig), 0);
    chk("stop_tooth", 32'(bus.tooth_num), 0);
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_gap", 32'(bus.gap), 0);
    chk("stop_revcnt", 32'(bus.rev_cnt), 3);
    bus.ena = 1'b1;
    step(1);
    chk("restart_busy", 32'(bus.busy), 1);
    chk("restart_rp", 32'(bus.rev_pulse), 1);
    chk("restart_tooth", 32'(bus.tooth_num), 0);

    // period 1 is run as 2
    bus.ena = 1'b0;
    step(1);
    bus.period = 24'd1;
    bus.ena = 1'b1;
    step(1);
    chk("p1_k0_vr", 32'(bus.vr_sig), 1);
    chk("p1_k0_busy", 32'(bus.busy), 1);
    step(1);
    chk("p1_k1_vr", 32'(bus.vr_sig), 0);
    chk("p1_k1_tooth", 32'(bus.tooth_num), 0);
    step(1);
    chk("p1_k2_vr", 32'(bus.vr_sig), 1);
    chk("p1_k2_tooth", 32'(bus.tooth_num), 1);
    step(9);
    chk("p1_k11_tooth", 32'(bus.tooth_num), 5);
    chk("p1_k11_gap", 32'(bus.gap), 1);
    // drop enable on the revolution wrap edge
    bus.ena = 1'b0;
    step(1);
    chk("wrapstop_busy", 32'(bus.busy), 0);
    chk("wrapstop_revcnt", 32'(bus.rev_cnt), 3);
    chk("wrapstop_tooth", 32'(bus.tooth_num), 0);

    // rejected config, then fixed
    bus.teeth_total = 8'd4;
    bus.teeth_missing = 4'd3;
    bus.ena = 1'b1;
    step(1);
    chk("bad_busy", 32'(bus.busy), 0);
    chk("bad_cfgerr", 32'(bus.cfg_err), 1);
    bus.teeth_missing = 4'd1;
    step(1);
    chk("fix_busy", 32'(bus.busy), 1);
    chk("fix_rp", 32'(bus.rev_pulse), 1);
    chk("fix_cfgerr", 32'(bus.cfg_err), 0);

    // invalid reload mid-revolution
    step(1);
    bus.teeth_missing = 4'd3;
    step(1);
    chk("mid_tooth", 32'(bus.tooth_num), 1);
    chk("mid_vr", 32'(bus.vr_sig), 1);
    step(5);
    chk("k7_tooth", 32'(bus.tooth_num), 3);
    chk("k7_gap", 32'(bus.gap), 1);
    chk("k7_busy", 32'(bus.busy), 1);
    step(1);
    chk("reload_busy", 32'(bus.busy), 0);
    chk("reload_cfgerr", 32'(bus.cfg_err), 1);
    chk("reload_revcnt", 32'(bus.rev_cnt), 4);
    bus.ena = 1'b0;
    step(1);
    chk("clr_cfgerr", 32'(bus.cfg_err), 0);

    // async reset while vr_sig is high
    bus.period = 24'd10;
    bus.teeth_total = 8'd6;
    bus.teeth_missing = 4'd2;
    bus.ena = 1'b1;
    step(1);
    chk("pre_rst_vr", 32'(bus.vr_sig), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_vr", 32'(bus.vr_sig), 0);
    chk("arst_revcnt", 32'(bus.rev_cnt), 0);
    chk("arst_tooth", 32'(bus.tooth_num), 0);
    chk("arst_rp", 32'(bus.rev_pulse), 0);
    bus.ena = 1'b0;
    step(2);
    rst = 1'b1;
    step(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
